// File: rtl/charge_port_arbiter.sv
// rtl/charge_port_arbiter.sv - round-robin charger arbiter with critical-level preemption
// Break-before-make: every grant is followed by a one-cycle GUARD and a one-cycle SELECT.
module charge_port_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int LEVEL_W      = 8,
  parameter int SLICE_CYCLES = 16,
  parameter int CRIT_LEVEL   = 20,
  parameter int FAST_LIMIT   = 80,
  parameter int FULL_LEVEL   = 100
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_PORTS-1:0]           req,
  input  logic [N_PORTS*LEVEL_W-1:0]   level,
  output logic [N_PORTS-1:0]           grant,
  output logic [$clog2(N_PORTS)-1:0]   grant_id,
  output logic                         charging,
  output logic                         fast_en,
  output logic                         slice_done
);

  localparam int ID_W = $clog2(N_PORTS);

  typedef enum logic [1:0] {IDLE, SELECT, CHARGE, GUARD} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [7:0]          slice_cnt;
  logic [N_PORTS-1:0]  elig;
  logic [N_PORTS-1:0]  crit;
  logic [N_PORTS-1:0]  cand;
  logic [ID_W-1:0]     win_idx;
  logic [LEVEL_W-1:0]  win_level;
  logic [ID_W-1:0]     rr_next;
  logic                any_elig;
  logic                exit_drop;
  logic                exit_preempt;
  logic                exit_slice;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      elig[i] = req[i] && (level[i*LEVEL_W +: LEVEL_W] < LEVEL_W'(FULL_LEVEL));
      crit[i] = elig[i] && (level[i*LEVEL_W +: LEVEL_W] < LEVEL_W'(CRIT_LEVEL));
    end
  end

  assign any_elig = |elig;
  assign cand     = (|crit) ? crit : elig;

  // First candidate at or after rr_ptr, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % N_PORTS;
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    win_level = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_id == ID_W'(i)) win_level = level[i*LEVEL_W +: LEVEL_W];
    end
  end

  assign rr_next      = (grant_id == ID_W'(N_PORTS-1)) ? '0 : grant_id + ID_W'(1);
  assign exit_drop    = !elig[grant_id];
  assign exit_preempt = !crit[grant_id] && (|(crit & ~grant));
  assign exit_slice   = (slice_cnt == 8'(SLICE_CYCLES-1));

  assign charging   = |grant;
  assign fast_en    = charging && (win_level < LEVEL_W'(FAST_LIMIT));
  // Only an expiry that actually ends the grant counts; drop and preemption take priority.
  assign slice_done = (state == CHARGE) && exit_slice && !exit_drop && !exit_preempt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      slice_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          if (any_elig) state <= SELECT;
        end
        SELECT: begin
          if (any_elig) begin
            grant     <= N_PORTS'(1) << win_idx;
            grant_id  <= win_idx;
            slice_cnt <= '0;
            state     <= CHARGE;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        CHARGE: begin
          if (exit_drop || exit_preempt || exit_slice) begin
            grant <= '0;
            state <= GUARD;
          end else begin
            slice_cnt <= slice_cnt + 8'd1;
          end
        end
        GUARD: begin
          grant  <= '0;
          rr_ptr <= rr_next;
          state  <= any_elig ? SELECT : IDLE;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charge_port_arbiter.sv
// tb/tb_charge_port_arbiter.sv - randomized bench for charge_port_arbiter against a rule-level model
module tb_charge_port_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SLICE = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] level;
  logic [N-1:0]   grant;
  logic [1:0]     grant_id;
  logic           charging;
  logic           fast_en;
  logic           slice_done;

  charge_port_arbiter #(
    .N_PORTS(N), .LEVEL_W(W), .SLICE_CYCLES(SLICE),
    .CRIT_LEVEL(20), .FAST_LIMIT(80), .FULL_LEVEL(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .level(level),
    .grant(grant), .grant_id(grant_id), .charging(charging),
    .fast_en(fast_en), .slice_done(slice_done)
  );

  always #5 clk = ~clk;

  int lv[N];
  bit rq[N];
  int tbl[12] = '{5, 15, 19, 20, 21, 50, 79, 80, 81, 99, 100, 120};

  // Model: who owns the charger, how many cycles it has held it, and pending arbitration steps.
  int m_owner, m_held, m_rr, m_last;
  bit m_pick, m_guard;

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit elig(int i);
    return rq[i] && lv[i] < 100;
  endfunction

  function automatic bit crit(int i);
    return elig(i) && lv[i] < 20;
  endfunction

  function automatic bit any_crit_except(int o);
    for (int i = 0; i < N; i++) if (i != o && crit(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_elig();
    for (int i = 0; i < N; i++) if (elig(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    bit use_crit;
    int idx;
    use_crit = any_crit_except(-1);
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (use_crit ? crit(idx) : elig(idx)) return idx;
    end
    return -1;
  endfunction

  function automatic bit owner_ends();
    return !elig(m_owner) || (!crit(m_owner) && any_crit_except(m_owner)) || m_held == SLICE;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_rr = 0; m_last = 0; m_pick = 0; m_guard = 0;
  endtask

  task automatic model_step();
    int w;
    if (!reset_n) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (owner_ends()) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_guard = 1;
      end else begin
        m_held++;
      end
    end else if (m_pick) begin
      w = pick();
      m_pick = 0;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end
    end else if (m_guard) begin
      m_guard = 0;
      m_pick  = any_elig();
    end else begin
      m_pick = any_elig();
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i]         = rq[i];
      level[i*W +: W] = W'(lv[i]);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    bit on, ef, es;
    on = m_owner >= 0;
    eg = on ? (N'(1) << m_owner) : '0;
    ef = on && lv[m_owner] < 80;
    es = on && elig(m_owner) && !(!crit(m_owner) && any_crit_except(m_owner)) && m_held == SLICE;
    check("grant", 32'(grant), 32'(eg));
    check("grant_id", 32'(grant_id), 32'(m_last));
    check("charging", 32'(charging), 32'(on));
    check("fast_en", 32'(fast_en), 32'(ef));
    check("slice_done", 32'(slice_done), 32'(es));
  endtask

  task automatic cycle();
    apply();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin rq[i] = 0; lv[i] = 50; end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_all();
    model_reset();
    apply();
    repeat (2) @(negedge clk);
    cycle();
    reset_n = 1'b1;

    // Single requester: latency, full slice, gap, re-grant.
    rq[0] = 1;
    repeat (40) cycle();

    // Round robin among 0, 1, 3.
    rq[1] = 1; rq[3] = 1;
    repeat (80) cycle();

    // Preemption by a critical pack, then no preemption between critical packs.
    clear_all();
    repeat (4) cycle();
    rq[1] = 1; lv[1] = 60;
    repeat (6) cycle();
    rq[2] = 1; lv[2] = 10;
    repeat (5) cycle();
    rq[3] = 1; lv[3] = 15;
    repeat (30) cycle();

    // Rate and full boundaries.
    clear_all();
    repeat (4) cycle();
    rq[0] = 1; lv[0] = 78;
    repeat (3) cycle();
    lv[0] = 79; cycle();
    lv[0] = 80; cycle();
    lv[0] = 100;
    repeat (10) cycle();

    // Request drop mid-slice.
    clear_all();
    repeat (4) cycle();
    rq[2] = 1;
    repeat (6) cycle();
    rq[2] = 0;
    repeat (4) cycle();

    // Randomized traffic with occasional asynchronous reset mid-operation.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) rq[i] = !rq[i];
        if ($urandom_range(0, 15) == 0) lv[i] = tbl[$urandom_range(0, 11)];
      end
      if (n % 700 == 350) begin
        apply();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_grant", 32'(grant), 32'd0);
        check("rst_async_charging", 32'(charging), 32'd0);
        model_reset();
        cycle();
        reset_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/charge_port_arbiter.md
# charge_port_arbiter

Time-sliced arbiter that shares one charging datapath (fast/slow charger) between `N_PORTS` battery packs. Each pack raises a charge request and reports its state-of-charge. The arbiter grants the charger to one pack at a time, round-robin, with preemptive priority for critically low packs. It also tells the charger whether the granted pack gets the fast or slow rate. It sits between the pack monitors and the charging module and gates that module's activity through `grant`/`charging`.

## Interface
- `N_PORTS`, 4: number of packs; 2..8.
- `LEVEL_W`, 8: width of each level field, in percent units.
- `SLICE_CYCLES`, 16: maximum grant length in cycles; 2..255.
- `CRIT_LEVEL`, 20: a level strictly below this is critical.
- `FAST_LIMIT`, 80: a level strictly below this selects the fast rate.
- `FULL_LEVEL`, 100: a level at or above this is full and not eligible.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_PORTS  per-pack charge request, level-sensitive.
- `level`  in  N_PORTS*LEVEL_W  packed levels; pack i occupies bits [i*LEVEL_W +: LEVEL_W].
- `grant`  out  N_PORTS  one-hot grant, registered.
- `grant_id`  out  clog2(N_PORTS)  index of the current or last winner, registered.
- `charging`  out  1  equals |grant.
- `fast_en`  out  1  charging && level[grant_id] < FAST_LIMIT (combinational).
- `slice_done`  out  1  one-cycle pulse when a grant ends by slice expiry.

## Operation
- Eligibility: port i is eligible when req[i] && level[i] < FULL_LEVEL. It is critical when it is eligible and level[i] < CRIT_LEVEL.
- State machine (registered): IDLE, SELECT, CHARGE, GUARD.
- IDLE: grant = 0. If any port is eligible, go to SELECT.
- SELECT (one cycle):
  - If any port is critical, the candidate set is the critical ports; otherwise it is all eligible ports.
  - Winner is the first candidate searching upward, with wrap, from rr_ptr.
  - Register the winner into grant/grant_id, clear the slice counter, go to CHARGE.
  - If no port is eligible, go to IDLE with grant = 0.
- CHARGE: grant[grant_id] = 1 and the slice counter increments every cycle. Leave for GUARD, clearing grant at that same edge, when the first of these holds in priority order:
  - (a) the winner drops req or reaches FULL_LEVEL.
  - (b) the winner is not critical and some other port is critical (preemption).
  - (c) the counter reaches SLICE_CYCLES-1. This also pulses slice_done in the cycle the counter equals SLICE_CYCLES-1.
- GUARD (one cycle, grant = 0, break-before-make):
  - rr_ptr <= (grant_id+1) mod N_PORTS.
  - Go to SELECT if any port is eligible, else IDLE.
- A winner that is still eligible after its slice competes again. With only one requester, it is re-granted after the 2-cycle gap.
- Reset values:
  - Outputs: grant = 0, grant_id = 0, charging = 0, fast_en = 0, slice_done = 0.
  - Internal: state = IDLE, rr_ptr = 0, slice counter = 0.
- Reset asserted mid-grant clears grant asynchronously, with no GUARD cycle.
- Illegal state encodings recover to IDLE with grant = 0.

## Timing
- req rises before edge E while in IDLE → SELECT after E → grant high after E+1. Grant latency is 2 cycles.
- An uninterrupted grant stays high exactly SLICE_CYCLES cycles.
- Gap between consecutive grants is exactly 2 cycles (GUARD, then SELECT).
- Early exit: a condition seen before edge E clears grant after E.
- Preemption of a non-critical winner ends its grant 1 cycle after the critical request is visible. The critical port is granted 2 cycles later.
- fast_en follows level combinationally while charging, so a rate change from fast to slow needs no re-arbitration.
- grant is never multi-hot. Among sampled outputs, grant is zero in IDLE, SELECT and GUARD.

## Test plan
- Single requester (used in every scenario below unless stated): port 0 at level 50, req held; SLICE_CYCLES = 16. Expect:
  - grant = 0001 two cycles after req.
  - 16 cycles high, slice_done pulses on the 16th.
  - 2-cycle gap, then re-grant.
  - fast_en = 1 throughout.
- Round-robin: ports 0, 1 and 3 all request at level 50. Expect grant order 0 → 1 → 3 → 0, each 16 cycles, with a 2-cycle gap between grants.
- Preemption: port 1 charging at level 60; port 2 requests at level 10. Expect:
  - port 1 grant drops 1 cycle later.
  - grant = 0100 2 cycles after that.
  - port 2 is not preempted by port 3 requesting at level 15; it runs its full slice.
- Full and rate boundaries: port 0 level ramps 78 → 79 → 80 during its grant, then is forced to 100. Expect:
  - fast_en goes 1 → 1 → 0.
  - grant drops 1 cycle after level 100.
  - no re-grant while level stays at 100.
- Request drop and reset: port 2 drops req in cycle 5 of its slice, so its grant clears 1 cycle later. On a second grant, assert reset_n = 0 mid-slice. Expect grant = 0 immediately, and after release the first grant goes to the lowest eligible index from rr_ptr = 0.
